text_console_ctrl: RTL and testbench

- Command-driven controller that owns the single address/write port of the 70-column character video memory in the typing game.
- Accepts put-char, backspace, newline and clear commands from the keyboard/game logic and maintains the text cursor.
- Sequences every memory access: single writes, full-screen clear, and a one-line scroll-up when the cursor runs off the bottom row.
- Sits between the game FSM and the video memory; the VGA character generator reads cursor_row/cursor_col.

---
 rtl/text_console_ctrl_if.sv | 26 ++
 rtl/text_console_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_text_console_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/text_console_ctrl_if.sv
// rtl/text_console_ctrl_if.sv - command and video-memory bus of the text console controller
interface text_console_ctrl_if #(
    parameter int AW = 12
) ();
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [7:0]    cmd_char;
    logic [AW-1:0] vm_addr;
    logic [7:0]    vm_wdata;
    logic          vm_wren;
    logic [7:0]    vm_rdata;
    logic [6:0]    cursor_row;
    logic [6:0]    cursor_col;
    logic          busy;

    modport master (
        output cmd_valid, cmd_op, cmd_char, vm_rdata,
        input  cmd_ready, vm_addr, vm_wdata, vm_wren, cursor_row, cursor_col, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_char, vm_rdata,
        output cmd_ready, vm_addr, vm_wdata, vm_wren, cursor_row, cursor_col, busy
    );
endinterface

// File: rtl/text_console_ctrl.sv
// rtl/text_console_ctrl.sv - cursor keeper and sole sequencer of the character video memory port
module text_console_ctrl #(
    parameter int         COLS  = 70,
    parameter int         ROWS  = 30,
    parameter int         AW    = 12,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic              clk,
    input  logic              rst,
    text_console_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_CLR,
        S_SC_RD,
        S_SC_WR,
        S_SC_FILL
    } state_t;

    localparam logic [1:0]    OP_PUT      = 2'd0;
    localparam logic [1:0]    OP_BKSP     = 2'd1;
    localparam logic [1:0]    OP_NEWLINE  = 2'd2;
    localparam logic [1:0]    OP_CLEAR    = 2'd3;
    localparam logic [6:0]    COL_MAX     = 7'(COLS - 1);
    localparam logic [6:0]    ROW_MAX     = 7'(ROWS - 1);
    localparam logic [AW-1:0] COLS_A      = AW'(COLS);
    localparam logic [AW-1:0] LAST_ADDR   = AW'(ROWS * COLS - 1);
    localparam logic [AW-1:0] SCROLL_LAST = AW'((ROWS - 1) * COLS - 1);
    localparam logic [AW-1:0] FILL_BASE   = AW'((ROWS - 1) * COLS);

    state_t        r_state, w_state_nx;
    logic [6:0]    r_row, w_row_nx;
    logic [6:0]    r_col, w_col_nx;
    logic [AW-1:0] r_addr, w_addr_nx;
    logic [7:0]    r_wdata, w_wdata_nx;
    logic          r_wren, w_wren_nx;
    logic [AW-1:0] r_idx, w_idx_nx;
    logic          r_scroll, w_scroll_nx;
    logic          r_ready;
    logic          r_busy;

    logic          w_accept;
    logic [AW-1:0] w_cur_addr;

    assign w_accept   = bus.cmd_valid & r_ready;
    assign w_cur_addr = AW'(r_row) * COLS_A + AW'(r_col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_row    <= '0;
            r_col    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wren   <= 1'b0;
            r_idx    <= '0;
            r_scroll <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_row    <= w_row_nx;
            r_col    <= w_col_nx;
            r_addr   <= w_addr_nx;
            r_wdata  <= w_wdata_nx;
            r_wren   <= w_wren_nx;
            r_idx    <= w_idx_nx;
            r_scroll <= w_scroll_nx;
            // Handshake and busy flags are registered copies of the next state.
            r_ready  <= (w_state_nx == S_IDLE);
            r_busy   <= (w_state_nx != S_IDLE);
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_row_nx    = r_row;
        w_col_nx    = r_col;
        w_addr_nx   = r_addr;
        w_wdata_nx  = r_wdata;
        w_wren_nx   = 1'b0;
        w_idx_nx    = r_idx;
        w_scroll_nx = r_scroll;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (bus.cmd_op)
                        OP_PUT: begin
                            w_state_nx = S_WR;
                            w_addr_nx  = w_cur_addr;
                            w_wdata_nx = bus.cmd_char;
                            w_wren_nx  = 1'b1;
                            if (r_col == COL_MAX) begin
                                w_col_nx = '0;
                                if (r_row == ROW_MAX) begin
                                    w_scroll_nx = 1'b1;
                                end else begin
                                    w_row_nx = r_row + 7'd1;
                                end
                            end else begin
                                w_col_nx = r_col + 7'd1;
                            end
                        end
                        OP_BKSP: begin
                            // Previous cell is always cur_addr-1, including the row wrap.
                            if (r_col != '0 || r_row != '0) begin
                                w_state_nx = S_WR;
                                w_addr_nx  = w_cur_addr - AW'(1);
                                w_wdata_nx = BLANK;
                                w_wren_nx  = 1'b1;
                                if (r_col != '0) begin
                                    w_col_nx = r_col - 7'd1;
                                end else begin
                                    w_row_nx = r_row - 7'd1;
                                    w_col_nx = COL_MAX;
                                end
                            end
                        end
                        OP_NEWLINE: begin
                            w_col_nx = '0;
                            if (r_row == ROW_MAX) begin
                                w_state_nx = S_SC_RD;
                                w_idx_nx   = '0;
                                w_addr_nx  = COLS_A;
                            end else begin
                                w_row_nx = r_row + 7'd1;
                            end
                        end
                        OP_CLEAR: begin
                            w_state_nx = S_CLR;
                            w_row_nx   = '0;
                            w_col_nx   = '0;
                            w_idx_nx   = '0;
                            w_addr_nx  = '0;
                            w_wdata_nx = BLANK;
                            w_wren_nx  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_WR: begin
                if (r_scroll) begin
                    w_state_nx  = S_SC_RD;
                    w_scroll_nx = 1'b0;
                    w_idx_nx    = '0;
                    w_addr_nx   = COLS_A;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_CLR, S_SC_FILL: begin
                if (r_idx == LAST_ADDR) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_idx_nx   = r_idx + AW'(1);
                    w_addr_nx  = r_idx + AW'(1);
                    w_wdata_nx = BLANK;
                    w_wren_nx  = 1'b1;
                end
            end
            S_SC_RD: begin
                // The write-data register doubles as the capture of the row below.
                w_state_nx = S_SC_WR;
                w_addr_nx  = r_idx;
                w_wdata_nx = bus.vm_rdata;
                w_wren_nx  = 1'b1;
            end
            S_SC_WR: begin
                if (r_idx == SCROLL_LAST) begin
                    w_state_nx = S_SC_FILL;
                    w_idx_nx   = FILL_BASE;
                    w_addr_nx  = FILL_BASE;
                    w_wdata_nx = BLANK;
                    w_wren_nx  = 1'b1;
                end else begin
                    w_state_nx = S_SC_RD;
                    w_idx_nx   = r_idx + AW'(1);
                    w_addr_nx  = r_idx + AW'(1) + COLS_A;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready  = r_ready;
    assign bus.busy       = r_busy;
    assign bus.vm_addr    = r_addr;
    assign bus.vm_wdata   = r_wdata;
    assign bus.vm_wren    = r_wren;
    assign bus.cursor_row = r_row;
    assign bus.cursor_col = r_col;
endmodule

// File: tb/tb_text_console_ctrl.sv
// tb/tb_text_console_ctrl.sv - scoreboard bench for text_console_ctrl with a behavioural video memory
module tb_text_console_ctrl;
    localparam int NCELL = 2100;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk;
    logic rst;
    text_console_ctrl_if #(.AW(12)) bus ();

    text_console_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem  [0:NCELL-1];
    logic [7:0] snap [0:NCELL-1];
    wr_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.vm_rdata = (int'(bus.vm_addr) < NCELL) ? mem[bus.vm_addr] : 8'h00;

    always @(posedge clk) begin
        if (bus.vm_wren && int'(bus.vm_addr) < NCELL) mem[bus.vm_addr] <= bus.vm_wdata;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int a, input logic [7:0] d);
        exp_q.push_back({12'(a), d});
    endtask

    // Monitor: every write the DUT presents must be the next expected one.
    always @(negedge clk) begin
        if (!rst && bus.vm_wren) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0h, none expected", bus.vm_addr, bus.vm_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", int'(bus.vm_addr), int'(e.addr));
                check("wr_data", int'(bus.vm_wdata), int'(e.data));
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [7:0] ch);
        int t;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_char  = ch;
        t = 0;
        while (!bus.cmd_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!bus.cmd_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.cmd_ready && t < 10000) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", int'(bus.cmd_ready), 1);
    endtask

    task automatic count_busy(output int cyc, output int wrs, output int rdy_busy);
        cyc = 0; wrs = 0; rdy_busy = 0;
        @(negedge clk);
        while (bus.busy && cyc < 10000) begin
            cyc++;
            if (bus.vm_wren) wrs++;
            if (bus.cmd_ready) rdy_busy++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc, wrs, rb, bad;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_char  = 8'h00;
        for (int a = 0; a < NCELL; a++) mem[a] = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", int'(bus.cmd_ready), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_wren", int'(bus.vm_wren), 0);
        check("rst_addr", int'(bus.vm_addr), 0);
        check("rst_wdata", int'(bus.vm_wdata), 0);
        check("rst_row", int'(bus.cursor_row), 0);
        check("rst_col", int'(bus.cursor_col), 0);
        rst = 1'b0;

        // PUT 'a' at (0,0)
        push(0, 8'h61);
        send(2'd0, 8'h61);
        @(negedge clk);
        check("put_wren", int'(bus.vm_wren), 1);
        check("put_busy", int'(bus.busy), 1);
        check("put_ready_low", int'(bus.cmd_ready), 0);
        check("put_row", int'(bus.cursor_row), 0);
        check("put_col", int'(bus.cursor_col), 1);
        @(negedge clk);
        check("put_ready_again", int'(bus.cmd_ready), 1);
        check("put_wren_off", int'(bus.vm_wren), 0);

        // fill row 0 up to column 68, then wrap and backspace across the wrap
        for (int c = 1; c <= 68; c++) begin
            push(c, 8'h41);
            send(2'd0, 8'h41);
        end
        push(69, 8'h7a);
        send(2'd0, 8'h7a);
        wait_idle();
        check("wrap_row", int'(bus.cursor_row), 1);
        check("wrap_col", int'(bus.cursor_col), 0);
        push(69, 8'h20);
        send(2'd1, 8'h00);
        wait_idle();
        check("bksp_wrap_row", int'(bus.cursor_row), 0);
        check("bksp_wrap_col", int'(bus.cursor_col), 69);

        // CLEAR with a PUT held on cmd_valid throughout
        for (int a = 0; a < NCELL; a++) push(a, 8'h20);
        send(2'd3, 8'h00);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd0;
        bus.cmd_char  = 8'h71;
        count_busy(cyc, wrs, rb);
        check("clr_busy_cycles", cyc, 2100);
        check("clr_write_cycles", wrs, 2100);
        check("clr_ready_while_busy", rb, 0);
        check("clr_ready_after", int'(bus.cmd_ready), 1);
        push(0, 8'h71);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        wait_idle();
        check("held_put_col", int'(bus.cursor_col), 1);

        // back to (0,0), then BKSP at origin followed immediately by PUT
        push(0, 8'h20);
        send(2'd1, 8'h00);
        wait_idle();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd1;
        @(posedge clk);
        #1;
        bus.cmd_op   = 2'd0;
        bus.cmd_char = 8'h6b;
        push(0, 8'h6b);
        @(negedge clk);
        check("bksp0_wren", int'(bus.vm_wren), 0);
        check("bksp0_busy", int'(bus.busy), 0);
        check("bksp0_ready", int'(bus.cmd_ready), 1);
        check("bksp0_col", int'(bus.cursor_col), 0);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("b2b_put_col", int'(bus.cursor_col), 1);
        check("b2b_put_busy", int'(bus.busy), 1);
        wait_idle();

        // walk to (29,5) and scroll with NEWLINE
        for (int r = 0; r < 29; r++) send(2'd2, 8'h00);
        for (int c = 0; c < 5; c++) begin
            push(2030 + c, 8'h70);
            send(2'd0, 8'h70);
        end
        wait_idle();
        check("pre_scroll_row", int'(bus.cursor_row), 29);
        check("pre_scroll_col", int'(bus.cursor_col), 5);
        for (int a = 0; a < NCELL; a++) mem[a] = 8'((a * 13 + 7) & 8'hff);
        mem[70] = 8'h62;
        for (int a = 0; a < NCELL; a++) snap[a] = mem[a];
        for (int i = 0; i < 2030; i++) push(i, snap[i + 70]);
        for (int a = 2030; a < NCELL; a++) push(a, 8'h20);
        send(2'd2, 8'h00);
        count_busy(cyc, wrs, rb);
        check("scroll_busy_cycles", cyc, 4130);
        check("scroll_write_cycles", wrs, 2100);
        check("scroll_mem0", int'(mem[0]), 8'h62);
        check("scroll_mem1", int'(mem[1]), 8'((71 * 13 + 7) & 8'hff));
        bad = 0;
        for (int a = 2030; a < NCELL; a++) if (mem[a] !== 8'h20) bad++;
        check("scroll_bottom_blank", bad, 0);
        check("scroll_row", int'(bus.cursor_row), 29);
        check("scroll_col", int'(bus.cursor_col), 0);
        check("queue_drained", exp_q.size(), 0);

        // reset in the middle of CLEAR
        for (int a = 0; a < NCELL; a++) push(a, 8'h20);
        send(2'd3, 8'h00);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_wren", int'(bus.vm_wren), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_row", int'(bus.cursor_row), 0);
        check("arst_col", int'(bus.cursor_col), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("arst_ready", int'(bus.cmd_ready), 1);
        push(0, 8'h72);
        send(2'd0, 8'h72);
        wait_idle();
        check("post_rst_col", int'(bus.cursor_col), 1);
        check("final_queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
